// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port RAM between the core's instruction-fetch port (I,
// read-only) and its load/store port (D, read/write). The grant and the RAM
// address/data/write-enable mux are decided combinationally in the cycle of
// the request. The combinational RAM read data is registered and returned to
// the winner one cycle later with a one-cycle rvalid pulse.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> conflicts go to the port not granted last
//                       undefined -> fixed priority, D always wins conflicts
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_req, i_addr          instruction read request and word address
//   i_gnt                  I granted this cycle (combinational)
//   i_rdata, i_rvalid      registered read data for I, one-cycle valid pulse
//   d_req, d_we, d_addr,
//   d_wdata                data request, write flag, word address, write data
//   d_gnt                  D granted this cycle (combinational), also the
//                          write acknowledge
//   d_rdata, d_rvalid      registered read data for D, valid pulse (reads only)
//   ram_A, ram_WD, ram_we  RAM address, write data, write enable
//   ram_RD                 RAM combinational read data of ram_A

module ram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_A,
    output logic [DATA_WIDTH-1:0] ram_WD,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_RD
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_state_t;

    rsp_state_t state;
    rsp_state_t next_state;

    logic last_d;
    logic d_wins;
    logic d_read;

    // Decide who takes a conflict. In the fixed-priority build last_d is
    // still tracked so both builds carry the same state; OR-ing it with a
    // constant 1 keeps it referenced while D always wins.
    always_comb begin
        d_wins = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        d_wins = ~last_d;
`else
        d_wins = last_d | 1'b1;
`endif
    end

    // Grants: D takes the RAM when it is alone or wins the conflict, I takes
    // it whenever it asks and D does not. The two are mutually exclusive.
    always_comb begin
        d_gnt  = d_req & (~i_req | d_wins);
        i_gnt  = i_req & ~d_gnt;
        d_read = d_gnt & ~d_we;
    end

    // RAM mux. Write data is always D's since I never writes; the write
    // enable is qualified by the D grant.
    always_comb begin
        ram_A  = d_gnt ? d_addr : i_addr;
        ram_WD = d_wdata;
        ram_we = d_gnt & d_we;
    end

    // Priority pointer: remembers whether the most recent grant went to D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (i_gnt || d_gnt) begin
            last_d <= d_gnt;
        end
    end

    // Response state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RSP_NONE;
        end else begin
            state <= next_state;
        end
    end

    // Next response: a read granted this cycle is answered next cycle.
    always_comb begin
        next_state = RSP_NONE;
        if (i_gnt) begin
            next_state = RSP_I;
        end else if (d_read) begin
            next_state = RSP_D;
        end
    end

    // Read data capture. Each register only loads on its own read grant so
    // the last returned value stays visible to its requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (i_gnt) begin
                i_rdata <= ram_RD;
            end
            if (d_read) begin
                d_rdata <= ram_RD;
            end
        end
    end

    assign i_rvalid = (state == RSP_I);
    assign d_rvalid = (state == RSP_D);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: a behavioural RAM drives ram_RD, while a
// separate reference memory plus arbitration model predicts grants, write
// enables, rvalid pulses and returned data for directed and random traffic.

module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic [DW-1:0] i_rdata;
    logic          i_rvalid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic [AW-1:0] ram_A;
    logic [DW-1:0] ram_WD;
    logic          ram_we;
    logic [DW-1:0] ram_RD;

    int checks;
    int failures;

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    logic          m_last_d;
    logic [DW-1:0] exp_irdata;
    logic [DW-1:0] exp_drdata;

    // Behavioural RAM seen by the DUT.
    logic [DW-1:0] ram [DEPTH];
    logic          fill_req;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rdata (i_rdata),
        .i_rvalid(i_rvalid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rdata (d_rdata),
        .d_rvalid(d_rvalid),
        .ram_A   (ram_A),
        .ram_WD  (ram_WD),
        .ram_we  (ram_we),
        .ram_RD  (ram_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial RAM contents; word 4 holds a NOP instruction.
    function automatic logic [DW-1:0] fillValue(input int k);
        if (k == 4) return 32'h0000_0013;
        return (k * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign ram_RD = ram[ram_A];

    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= fillValue(k);
        end else if (ram_we) begin
            ram[ram_A] <= ram_WD;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                               input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive the request, check grants against the model's
    // choice of winner, clock it, then check the response a cycle later.
    task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr,
                                 input logic dreq, input logic dwe,
                                 input logic [AW-1:0] daddr,
                                 input logic [DW-1:0] dwdata,
                                 output logic ig, output logic dg);
        logic winner_d;
        logic exp_irv;
        logic exp_drv;
        i_req   = ireq;
        i_addr  = iaddr;
        d_req   = dreq;
        d_we    = dwe;
        d_addr  = daddr;
        d_wdata = dwdata;
        #1;
        // Winner: the only requester, or on a conflict the arbitration rule.
        if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner_d = (m_last_d == 1'b0);
`else
            winner_d = 1'b1;
`endif
        end else begin
            winner_d = dreq;
        end
        dg = dreq && winner_d;
        ig = ireq && !dg;
        checkOutput("i_gnt", i_gnt, ig);
        checkOutput("d_gnt", d_gnt, dg);
        checkOutput("ram_we", ram_we, dg && dwe);
        checkOutput("gnt_exclusive", i_gnt & d_gnt, 0);
        exp_irv = ig;
        exp_drv = dg && !dwe;
        if (ig) exp_irdata = ref_mem[iaddr];
        if (exp_drv) exp_drdata = ref_mem[daddr];
        if (dg && dwe) ref_mem[daddr] = dwdata;
        if (ig || dg) m_last_d = dg;
        @(posedge clk);
        #1;
        checkOutput("i_rvalid", i_rvalid, exp_irv);
        checkOutput("d_rvalid", d_rvalid, exp_drv);
        checkOutput("i_rdata", i_rdata, exp_irdata);
        checkOutput("d_rdata", d_rdata, exp_drdata);
    endtask

    initial begin
        logic          ig;
        logic          dg;
        logic [3:0]    iseq;
        logic          ir;
        logic          dr;
        logic          dw;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [DW-1:0] wd;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        fill_req = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = fillValue(k);
        m_last_d   = 1'b1;
        exp_irdata = '0;
        exp_drdata = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_i_rvalid", i_rvalid, 0);
        checkOutput("rst_d_rvalid", d_rvalid, 0);
        checkOutput("rst_i_rdata", i_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        fill_req = 1'b0;
        rst_n    = 1'b1;

        $display("[TB] idle and single-port accesses");
        applyStimulus(0, 0, 0, 0, 0, 0, ig, dg);
        applyStimulus(1, 10'h004, 0, 0, 0, 0, ig, dg);
        checkOutput("i_fetch_nop", i_rdata, 32'h0000_0013);
        applyStimulus(0, 0, 1, 1, 10'h010, 32'hDEAD_BEEF, ig, dg);
        applyStimulus(0, 0, 1, 0, 10'h010, 0, ig, dg);
        checkOutput("d_read_back", d_rdata, 32'hDEAD_BEEF);

        $display("[TB] four cycles of contention");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 10'h020 + 10'(c), 1, 0, 10'h030 + 10'(c), 0, ig, dg);
            iseq[3-c] = ig;
        end
`ifdef ARB_ROUND_ROBIN_EN
        checkOutput("contention_order", iseq, 4'b1010);
`else
        checkOutput("contention_order", iseq, 4'b0000);
`endif
        applyStimulus(1, 10'h023, 0, 0, 0, 0, ig, dg);
        checkOutput("i_after_d_drops", ig, 1);

        $display("[TB] reset while a D read is in flight");
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'h010;
        #1;
        checkOutput("inflight_d_gnt", d_gnt, 1);
        @(posedge clk);
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        m_last_d   = 1'b1;
        exp_irdata = '0;
        exp_drdata = '0;
        checkOutput("inflight_d_rvalid", d_rvalid, 0);
        checkOutput("inflight_d_rdata", d_rdata, 0);
        @(posedge clk);
        #1;
        checkOutput("inflight_d_rvalid_hold", d_rvalid, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, ig, dg);
        applyStimulus(1, 10'h004, 1, 0, 10'h010, 0, ig, dg);
`ifdef ARB_ROUND_ROBIN_EN
        checkOutput("first_conflict_after_reset", ig, 1);
`else
        checkOutput("first_conflict_after_reset", ig, 0);
`endif

        $display("[TB] random traffic");
        ir = 1'b0; dr = 1'b0; dw = 1'b0;
        ia = '0; da = '0; wd = '0;
        ig = 1'b0; dg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!ir || ig) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = AW'($urandom_range(0, 15));
            end
            if (!dr || dg) begin
                dr = ($urandom_range(0, 2) != 0);
                dw = 1'($urandom_range(0, 1));
                da = AW'($urandom_range(0, 15));
                wd = $urandom;
            end
            applyStimulus(ir, ia, dr, dw, da, wd, ig, dg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
